// File: rtl/axi_wr_pkg.sv
// Shared definitions for the two-channel AXI write scheduler: FSM encoding,
// response codes, default buffer layout and the burst-size helper.
package axi_wr_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_UPDATE    = 2'd3
    } sched_state_t;

    localparam logic [1:0]  BRESP_OKAY      = 2'b00;

    localparam logic [27:0] DEF_CH0_BASE    = 28'h000_0000;
    localparam logic [27:0] DEF_CH1_BASE    = 28'h080_0000;
    localparam logic [27:0] DEF_BUF_STRIDE  = 28'h020_0000;
    localparam logic [27:0] DEF_FRAME_BYTES = 28'h012_C000;

    function automatic int burst_bytes(input int beats, input int data_w);
        return beats * data_w / 8;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; combinational, one-hot grant.
// On a tie the requester that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi_wr_sched.sv
// Round-robin write scheduler in front of axi_wr_ctrl: grants one burst at a
// time to two FIFO sources and walks per-channel ping-pong frame buffers.
module axi_wr_sched
    import axi_wr_pkg::*;
#(
    parameter int                            C_M_AXI_ADDR_WIDTH = 28,
    parameter int                            C_M_AXI_DATA_WIDTH = 16,
    parameter int                            BURST_LEN          = 64,
    parameter int                            FIFO_CNT_W         = 11,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] FRAME_BYTES        = DEF_FRAME_BYTES,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] CH0_BASE           = DEF_CH0_BASE,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] CH1_BASE           = DEF_CH1_BASE,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BUF_STRIDE         = DEF_BUF_STRIDE,
    parameter int                            TIMEOUT_CYC        = 4096
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic [1:0]                    ch_en,
    input  logic [1:0]                    ch_frame_sync,
    input  logic [FIFO_CNT_W-1:0]         ch0_fifo_cnt,
    input  logic [FIFO_CNT_W-1:0]         ch1_fifo_cnt,
    input  logic                          wr_done,
    input  logic                          wr_err,
    output logic                          wr_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]                    wr_len,
    output logic [1:0]                    ch_rd_sel,
    output logic [1:0]                    ch_frame_done,
    output logic [1:0]                    ch_buf_idx,
    output logic                          sched_err
);

    localparam int                            AW   = C_M_AXI_ADDR_WIDTH;
    localparam int                            WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AW-1:0]                 BB   = AW'(burst_bytes(BURST_LEN, C_M_AXI_DATA_WIDTH));
    localparam logic [FIFO_CNT_W-1:0]         THR  = FIFO_CNT_W'(BURST_LEN);

    sched_state_t     state_q, state_d;
    logic             gnt_q;
    logic             last_grant_q;
    logic [AW-1:0]    offset_q [2];
    logic [1:0]       buf_idx_q;
    logic [1:0]       sync_pend_q;
    logic             adv_q;
    logic [WD_W-1:0]  wd_cnt_q;
    logic             sched_err_q;
    logic [AW-1:0]    wr_addr_q;

    logic [1:0]       elig;
    logic [1:0]       gnt_oh;
    logic             timeout;
    logic             sync_g;
    logic             frame_wrap;
    logic [AW-1:0]    eff_off [2];
    logic [AW-1:0]    addr_ch [2];
    logic [AW-1:0]    addr_sel;

    assign elig[0] = ch_en[0] && (ch0_fifo_cnt >= THR);
    assign elig[1] = ch_en[1] && (ch1_fifo_cnt >= THR);

    rr_arb2 u_arb (
        .req        (elig),
        .last_grant (last_grant_q),
        .grant      (gnt_oh)
    );

    // A sync arriving in the grant cycle already restarts the frame for this burst.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            eff_off[i] = ch_frame_sync[i] ? '0 : offset_q[i];
        end
        addr_ch[0] = CH0_BASE + (buf_idx_q[0] ? BUF_STRIDE : '0) + eff_off[0];
        addr_ch[1] = CH1_BASE + (buf_idx_q[1] ? BUF_STRIDE : '0) + eff_off[1];
        addr_sel   = gnt_oh[0] ? addr_ch[0] : addr_ch[1];
    end

    assign sync_g     = sync_pend_q[gnt_q] | ch_frame_sync[gnt_q];
    assign frame_wrap = adv_q && !sync_g && ((offset_q[gnt_q] + BB) == FRAME_BYTES);

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        unique case (state_q)
            S_IDLE:      if (|elig) state_d = S_START;
            S_START:     state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (wr_done) begin
                    state_d = S_UPDATE;
                end else if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    state_d = S_IDLE;
                    timeout = 1'b1;
                end
            end
            S_UPDATE:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q      <= S_IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            offset_q[0]  <= '0;
            offset_q[1]  <= '0;
            buf_idx_q    <= 2'b00;
            sync_pend_q  <= 2'b00;
            adv_q        <= 1'b0;
            wd_cnt_q     <= '0;
            sched_err_q  <= 1'b0;
            wr_addr_q    <= '0;
        end else begin
            state_q  <= state_d;
            wd_cnt_q <= (state_q == S_WAIT_DONE) ? wd_cnt_q + 1'b1 : '0;

            if (state_q == S_IDLE && |elig) begin
                gnt_q     <= gnt_oh[1];
                wr_addr_q <= addr_sel;
            end

            if (state_q == S_WAIT_DONE && wr_done) begin
                adv_q <= !wr_err;
            end

            if ((wr_done && (state_q != S_WAIT_DONE || wr_err)) || timeout) begin
                sched_err_q <= 1'b1;
            end

            for (int i = 0; i < 2; i++) begin
                if (ch_frame_sync[i]) begin
                    if (state_q != S_IDLE && gnt_q == 1'(i)) begin
                        sync_pend_q[i] <= 1'b1;
                    end else begin
                        offset_q[i] <= '0;
                    end
                end
            end

            // Burst retired (or abandoned): resolve the granted channel's position.
            if (state_q == S_UPDATE) begin
                last_grant_q       <= gnt_q;
                sync_pend_q[gnt_q] <= 1'b0;
                if (sync_g) begin
                    offset_q[gnt_q] <= '0;
                end else if (frame_wrap) begin
                    offset_q[gnt_q]  <= '0;
                    buf_idx_q[gnt_q] <= ~buf_idx_q[gnt_q];
                end else if (adv_q) begin
                    offset_q[gnt_q] <= offset_q[gnt_q] + BB;
                end
            end else if (timeout) begin
                sync_pend_q[gnt_q] <= 1'b0;
                if (sync_g) offset_q[gnt_q] <= '0;
            end
        end
    end

    assign wr_start      = (state_q == S_START);
    assign wr_addr       = wr_addr_q;
    assign wr_len        = 8'(BURST_LEN - 1);
    assign ch_rd_sel     = (state_q == S_START || state_q == S_WAIT_DONE)
                         ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign ch_frame_done = (state_q == S_UPDATE && frame_wrap)
                         ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign ch_buf_idx    = buf_idx_q;
    assign sched_err     = sched_err_q;

endmodule

// File: tb/tb_axi_wr_sched.sv
// Directed bench for axi_wr_sched, built with a 256-byte frame so that two
// 128-byte bursts complete one frame buffer.
module tb_axi_wr_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ch_en;
    logic [1:0]  ch_frame_sync;
    logic [10:0] ch0_fifo_cnt;
    logic [10:0] ch1_fifo_cnt;
    logic        wr_done;
    logic        wr_err;
    logic        wr_start;
    logic [27:0] wr_addr;
    logic [7:0]  wr_len;
    logic [1:0]  ch_rd_sel;
    logic [1:0]  ch_frame_done;
    logic [1:0]  ch_buf_idx;
    logic        sched_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_wr_sched #(
        .FRAME_BYTES (28'd256)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .ch_en         (ch_en),
        .ch_frame_sync (ch_frame_sync),
        .ch0_fifo_cnt  (ch0_fifo_cnt),
        .ch1_fifo_cnt  (ch1_fifo_cnt),
        .wr_done       (wr_done),
        .wr_err        (wr_err),
        .wr_start      (wr_start),
        .wr_addr       (wr_addr),
        .wr_len        (wr_len),
        .ch_rd_sel     (ch_rd_sel),
        .ch_frame_done (ch_frame_done),
        .ch_buf_idx    (ch_buf_idx),
        .sched_err     (sched_err)
    );

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        ch_en         = 2'b00;
        ch_frame_sync = 2'b00;
        ch0_fifo_cnt  = '0;
        ch1_fifo_cnt  = '0;
        wr_done       = 1'b0;
        wr_err        = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic wait_start(input int limit, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < limit) begin
            cycles(1);
            cyc++;
            if (wr_start) got = 1'b1;
        end
    endtask

    // Leaves the bench at the UPDATE-state sample point.
    task automatic pulse_done(input logic err);
        wr_done = 1'b1;
        wr_err  = err;
        cycles(1);
        wr_done = 1'b0;
        wr_err  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ch_en = 2'b00; ch_frame_sync = 2'b00; ch0_fifo_cnt = '0; ch1_fifo_cnt = '0;
        wr_done = 1'b0; wr_err = 1'b0;
        cycles(2);
        n_checks++;
        if ({wr_start, wr_addr, ch_rd_sel, ch_frame_done, ch_buf_idx, sched_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got start=%b addr=%h sel=%b fd=%b buf=%b err=%b, expected all 0",
                     wr_start, wr_addr, ch_rd_sel, ch_frame_done, ch_buf_idx, sched_err);
        end
        n_checks++;
        if (wr_len !== 8'd63) begin
            n_fail++;
            $display("FAIL reset_wr_len: got %0d expected 63", wr_len);
        end
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic test_single();
        bit got; int cyc;
        do_reset();
        ch_en = 2'b01; ch0_fifo_cnt = 11'd64;
        wait_start(20, got, cyc);
        n_checks++;
        if (!got || cyc != 1) begin
            n_fail++;
            $display("FAIL single_start_latency: got seen=%0d cycles=%0d expected seen=1 cycles=1", got, cyc);
        end
        n_checks++;
        if (wr_addr !== 28'h0000000 || wr_len !== 8'd63 || ch_rd_sel !== 2'b01) begin
            n_fail++;
            $display("FAIL single_first_burst: got addr=%h len=%0d sel=%b expected 0000000 63 01",
                     wr_addr, wr_len, ch_rd_sel);
        end
        cycles(1);
        pulse_done(1'b0);
        n_checks++;
        if (ch_rd_sel !== 2'b00 || ch_frame_done !== 2'b00) begin
            n_fail++;
            $display("FAIL single_update: got sel=%b fd=%b expected 00 00", ch_rd_sel, ch_frame_done);
        end
        wait_start(20, got, cyc);
        n_checks++;
        if (!got || cyc != 2 || wr_addr !== 28'h0000080) begin
            n_fail++;
            $display("FAIL single_second_burst: got seen=%0d cycles=%0d addr=%h expected 1 2 0000080",
                     got, cyc, wr_addr);
        end
    endtask

    task automatic test_threshold();
        bit got; int cyc; int starts;
        do_reset();
        ch_en = 2'b01; ch0_fifo_cnt = 11'd63;
        starts = 0;
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            if (wr_start) starts++;
        end
        n_checks++;
        if (starts != 0) begin
            n_fail++;
            $display("FAIL threshold_below: got %0d starts expected 0", starts);
        end
        ch0_fifo_cnt = 11'd64;
        wait_start(20, got, cyc);
        n_checks++;
        if (!got || cyc != 1 || wr_addr !== 28'h0000000) begin
            n_fail++;
            $display("FAIL threshold_reached: got seen=%0d cycles=%0d addr=%h expected 1 1 0000000",
                     got, cyc, wr_addr);
        end
    endtask

    task automatic test_round_robin();
        bit got; int cyc;
        logic [1:0]  exp_sel  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [27:0] exp_addr [4] = '{28'h0000000, 28'h0800000, 28'h0000080, 28'h0800080};
        do_reset();
        ch_en = 2'b11; ch0_fifo_cnt = 11'd64; ch1_fifo_cnt = 11'd64;
        for (int k = 0; k < 4; k++) begin
            wait_start(20, got, cyc);
            n_checks++;
            if (!got || ch_rd_sel !== exp_sel[k] || wr_addr !== exp_addr[k]) begin
                n_fail++;
                $display("FAIL rr_burst%0d: got seen=%0d sel=%b addr=%h expected 1 %b %h",
                         k, got, ch_rd_sel, wr_addr, exp_sel[k], exp_addr[k]);
            end
            cycles(9);
            pulse_done(1'b0);
        end
    endtask

    task automatic test_frame_wrap();
        bit got; int cyc;
        do_reset();
        ch_en = 2'b01; ch0_fifo_cnt = 11'd64;
        wait_start(20, got, cyc);
        cycles(1);
        pulse_done(1'b0);
        n_checks++;
        if (ch_frame_done !== 2'b00) begin
            n_fail++;
            $display("FAIL frame_first_done: got fd=%b expected 00", ch_frame_done);
        end
        wait_start(20, got, cyc);
        n_checks++;
        if (!got || wr_addr !== 28'h0000080) begin
            n_fail++;
            $display("FAIL frame_second_addr: got seen=%0d addr=%h expected 1 0000080", got, wr_addr);
        end
        cycles(1);
        pulse_done(1'b0);
        n_checks++;
        if (ch_frame_done !== 2'b01) begin
            n_fail++;
            $display("FAIL frame_done_pulse: got fd=%b expected 01", ch_frame_done);
        end
        cycles(1);
        n_checks++;
        if (ch_buf_idx !== 2'b01 || ch_frame_done !== 2'b00) begin
            n_fail++;
            $display("FAIL frame_buf_toggle: got buf=%b fd=%b expected 01 00", ch_buf_idx, ch_frame_done);
        end
        wait_start(20, got, cyc);
        n_checks++;
        if (!got || wr_addr !== 28'h0200000) begin
            n_fail++;
            $display("FAIL frame_next_buffer: got seen=%0d addr=%h expected 1 0200000", got, wr_addr);
        end
    endtask

    task automatic test_errors();
        bit got; int cyc;
        do_reset();
        ch_en = 2'b01; ch0_fifo_cnt = 11'd64;
        wait_start(20, got, cyc);
        cycles(4096);
        n_checks++;
        if (sched_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: got err=%b expected 0", sched_err);
        end
        cycles(1);
        n_checks++;
        if (sched_err !== 1'b1 || ch_rd_sel !== 2'b00 || wr_start !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fire: got err=%b sel=%b start=%b expected 1 00 0",
                     sched_err, ch_rd_sel, wr_start);
        end
        wait_start(20, got, cyc);
        n_checks++;
        if (!got || cyc != 1 || wr_addr !== 28'h0000000) begin
            n_fail++;
            $display("FAIL timeout_retry: got seen=%0d cycles=%0d addr=%h expected 1 1 0000000",
                     got, cyc, wr_addr);
        end

        do_reset();
        ch_en = 2'b01; ch0_fifo_cnt = 11'd64;
        wait_start(20, got, cyc);
        cycles(1);
        pulse_done(1'b1);
        n_checks++;
        if (sched_err !== 1'b1 || ch_frame_done !== 2'b00) begin
            n_fail++;
            $display("FAIL bresp_err_flag: got err=%b fd=%b expected 1 00", sched_err, ch_frame_done);
        end
        wait_start(20, got, cyc);
        n_checks++;
        if (!got || wr_addr !== 28'h0000000) begin
            n_fail++;
            $display("FAIL bresp_err_no_advance: got seen=%0d addr=%h expected 1 0000000", got, wr_addr);
        end
        cycles(1);
        pulse_done(1'b0);
        wait_start(20, got, cyc);
        n_checks++;
        if (!got || wr_addr !== 28'h0000080) begin
            n_fail++;
            $display("FAIL bresp_ok_advance: got seen=%0d addr=%h expected 1 0000080", got, wr_addr);
        end

        do_reset();
        pulse_done(1'b0);
        cycles(1);
        n_checks++;
        if (sched_err !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_done: got err=%b expected 1", sched_err);
        end
    endtask

    task automatic test_sync_and_reset();
        bit got; int cyc;
        do_reset();
        ch_en = 2'b01; ch0_fifo_cnt = 11'd64;
        wait_start(20, got, cyc);
        cycles(1);
        pulse_done(1'b0);
        wait_start(20, got, cyc);
        cycles(1);
        ch_frame_sync = 2'b01;
        cycles(1);
        ch_frame_sync = 2'b00;
        pulse_done(1'b0);
        n_checks++;
        if (ch_frame_done !== 2'b00) begin
            n_fail++;
            $display("FAIL sync_no_frame_done: got fd=%b expected 00", ch_frame_done);
        end
        wait_start(20, got, cyc);
        n_checks++;
        if (!got || wr_addr !== 28'h0000000 || ch_buf_idx !== 2'b00) begin
            n_fail++;
            $display("FAIL sync_restart: got seen=%0d addr=%h buf=%b expected 1 0000000 00",
                     got, wr_addr, ch_buf_idx);
        end
        cycles(1);
        pulse_done(1'b0);
        wait_start(20, got, cyc);
        cycles(1);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({wr_start, wr_addr, ch_rd_sel, ch_frame_done, ch_buf_idx, sched_err} !== '0) begin
            n_fail++;
            $display("FAIL midburst_reset: got start=%b addr=%h sel=%b fd=%b buf=%b err=%b expected all 0",
                     wr_start, wr_addr, ch_rd_sel, ch_frame_done, ch_buf_idx, sched_err);
        end
        cycles(1);
        rst_n = 1'b1;
        wait_start(20, got, cyc);
        n_checks++;
        if (!got || wr_addr !== 28'h0000000) begin
            n_fail++;
            $display("FAIL post_reset_addr: got seen=%0d addr=%h expected 1 0000000", got, wr_addr);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_threshold();
        test_round_robin();
        test_frame_wrap();
        test_errors();
        test_sync_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
